mips_mem_stage: RTL and testbench
=================================

// Module: mips_mem_stage
// PURPOSE
//  - MEM stage of the 5-stage MIPS pipeline. Sits between EX and WB.
//  - Registers EX results (EX/MEM), reads/writes the data memory, sizes and extends load data,
//    and registers the write-back tuple (MEM/WB) that drives the register-file write port.
//  - Data memory is word-indexed: the ALU result is the word index, not a byte address.
//    Sub-word ops use the low lanes of the addressed word.
// PARAMETERS
//  DMEM_DEPTH  1024  data memory depth in 32-bit words (power of 2)
//  AW          10    word-index width, = log2(DMEM_DEPTH)
// PORTS
//  clk            in   1   pipeline clock
//  rst            in   1   synchronous reset, active-high
//  stall          in   1   hold both stage registers; suppress memory write
//  flush          in   1   load a bubble into EX/MEM
//  ex_valid       in   1   EX output holds a real instruction
//  ex_opcode      in   6   instruction opcode
//  ex_alu_out     in   32  ALU result (memory word index, or the WB value for non-loads)
//  ex_store_data  in   32  rt value, used by stores
//  ex_wr_addr     in   5   destination register
//  ex_wr_en       in   1   instruction writes the register file
//  w_mem_out_data out  32  sized/extended load data, combinational in the MEM cycle; 0 for non-loads
//  w_wb_wr_data   out  32  registered WB data
//  w_wb_wr_addr   out  5   registered WB register index
//  w_wb_wr_en     out  1   registered WB enable (valid & wr_en & addr!=0)
//  mem_err        out  1   sticky out-of-range flag (only with MIPS_MEM_RANGE_CHK_EN)
// BEHAVIOUR
//  - Reset: EX/MEM and MEM/WB valid=0. All w_wb_* outputs = 0. mem_err = 0. Memory contents are untouched.
//  - Pipeline registers:
//    - An EX tuple captured at edge N gives w_mem_out_data during cycle N..N+1.
//    - The corresponding w_wb_* outputs are valid after edge N+1. Latency is 2 edges from EX to WB.
//  - Stall: both registers hold and no memory write occurs. A stalled store commits once, in the first
//    non-stalled cycle.
//  - Flush: EX/MEM valid<=0 at the next edge. MEM/WB still advances. Stall has priority over flush.
//  - Read: asynchronous from the registered index idx = alu_out[AW-1:0].
//  - Load opcodes:
//    - 32 lb: sext byte[7:0]
//    - 33 lh: sext [15:0]
//    - 34, 35 lw: full word
//    - 36 lbu: zext [7:0]
//    - 37 lhu: zext [15:0]
//  - Store opcodes, write at the clock edge ending the MEM cycle when valid and !stall:
//    - 40 sb: word[7:0] <= sd[7:0]
//    - 41 sh: word[15:0] <= sd[15:0]
//    - 43 sw: full word
//    - Untouched lanes are preserved.
//  - Store then load to the same index in the next instruction: the load sees the new data, because the
//    write lands on the edge before the load's MEM cycle. No forwarding is needed.
//  - WB mux: opcodes 32..37 select w_mem_out_data; otherwise ex_alu_out. Stores and branches have
//    wr_en=0 from EX.
//  - Writes to r0 are squashed: w_wb_wr_en=0 when addr==0.
//  - Reset asserted mid-operation: an in-flight store in MEM is dropped (no write). Pipeline registers clear.
// CONFIGURATION
//  MIPS_MEM_RANGE_CHK_EN
//   - Defined: alu_out >= DMEM_DEPTH on a valid load/store sets mem_err (sticky until rst). That load
//     returns 0 and that store is dropped.
//   - Undefined: the index wraps modulo DMEM_DEPTH, and mem_err is tied to 0.
// STRUCTURE
//  - mips_pkg: opcode localparams (OP_LB..OP_SW, OP_RTYPE), the is_load/is_store functions, and the
//    data width constant.
//  - Sub-module mips_dmem: DMEM_DEPTH x 32 memory with async read, sync write, and a 4-bit byte-lane
//    write mask.
//  - Stage logic (registers, extension, WB mux, range check) lives in mips_mem_stage.
// TESTING
//  1. sw r5=0xDEADBEEF at idx 4, then lw idx 4 -> w_mem_out_data=0xDEADBEEF. Next edge: wb_data=0xDEADBEEF,
//     wb_addr=rt, wb_en=1.
//  2. word 8=0x000080F0. lb -> 0xFFFFFFF0; lbu -> 0x000000F0; lh -> 0xFFFF80F0; lhu -> 0x000080F0.
//  3. word 2=0x11223344, then sb 0xAA and sh 0xBBCC at idx 2 -> lw reads 0x1122BBCC (byte write then
//     half write, upper lanes kept).
//  4. sw held 3 cycles by stall, then released -> exactly one write. wb_* frozen during the stall.
//     flush on a load -> wb_en=0 two edges later.
//  5. add rd=0 with alu_out=7 -> wb_en=0. addi rt=9, alu_out=0x10 -> wb_data=0x10, w_mem_out_data=0.
//  6. With MIPS_MEM_RANGE_CHK_EN: lw idx 1024 -> data 0, mem_err=1 and it stays set. Without the macro:
//     it reads idx 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared opcode constants, pipeline tuple type and load/store decode helpers for the MIPS MEM stage.
package mips_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [5:0] OP_RTYPE  = 6'd0;
    localparam logic [5:0] OP_LB     = 6'd32;
    localparam logic [5:0] OP_LH     = 6'd33;
    localparam logic [5:0] OP_LW_ALT = 6'd34;
    localparam logic [5:0] OP_LW     = 6'd35;
    localparam logic [5:0] OP_LBU    = 6'd36;
    localparam logic [5:0] OP_LHU    = 6'd37;
    localparam logic [5:0] OP_SB     = 6'd40;
    localparam logic [5:0] OP_SH     = 6'd41;
    localparam logic [5:0] OP_SW     = 6'd43;

    typedef struct packed {
        logic              valid;
        logic [5:0]        opcode;
        logic [DATA_W-1:0] alu_out;
        logic [DATA_W-1:0] store_data;
        logic [4:0]        wr_addr;
        logic              wr_en;
    } ex_mem_t;

    function automatic logic is_load(input logic [5:0] op);
        return (op >= OP_LB) && (op <= OP_LHU);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mips_mem_stage_if.sv
// EX-to-MEM request bundle and MEM/WB result bundle of the MIPS MEM stage.
interface mips_mem_stage_if;

    logic        stall;
    logic        flush;
    logic        ex_valid;
    logic [5:0]  ex_opcode;
    logic [31:0] ex_alu_out;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_wr_addr;
    logic        ex_wr_en;

    logic [31:0] w_mem_out_data;
    logic [31:0] w_wb_wr_data;
    logic [4:0]  w_wb_wr_addr;
    logic        w_wb_wr_en;
    logic        mem_err;

    modport master (
        output stall, flush, ex_valid, ex_opcode, ex_alu_out, ex_store_data, ex_wr_addr, ex_wr_en,
        input  w_mem_out_data, w_wb_wr_data, w_wb_wr_addr, w_wb_wr_en, mem_err
    );

    modport slave (
        input  stall, flush, ex_valid, ex_opcode, ex_alu_out, ex_store_data, ex_wr_addr, ex_wr_en,
        output w_mem_out_data, w_wb_wr_data, w_wb_wr_addr, w_wb_wr_en, mem_err
    );

endinterface

// File: rtl/mips_dmem.sv
// Word-indexed data memory: asynchronous read, synchronous write with a 4-bit byte-lane mask.
module mips_dmem
    import mips_pkg::*;
#(
    parameter int unsigned Depth = 1024,
    parameter int unsigned Aw    = 10
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [3:0]        be_i,
    input  logic [Aw-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mips_mem_stage.sv
// MIPS MEM stage: EX/MEM register, data memory access, load extension, MEM/WB register.
// Optional range checking with sticky mem_err is enabled by defining MIPS_MEM_RANGE_CHK_EN.
module mips_mem_stage
    import mips_pkg::*;
#(
    parameter int unsigned DMEM_DEPTH = 1024,
    parameter int unsigned AW         = 10
) (
    input  logic              clk,
    input  logic              rst,
    mips_mem_stage_if.slave   bus
);

    ex_mem_t exm_d, exm_q;

    always_comb begin
        exm_d = exm_q;
        if (!bus.stall) begin
            exm_d.valid      = bus.ex_valid & ~bus.flush;
            exm_d.opcode     = bus.ex_opcode;
            exm_d.alu_out    = bus.ex_alu_out;
            exm_d.store_data = bus.ex_store_data;
            exm_d.wr_addr    = bus.ex_wr_addr;
            exm_d.wr_en      = bus.ex_wr_en;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exm_q <= '0;
        end else begin
            exm_q <= exm_d;
        end
    end

    logic in_range;
`ifdef MIPS_MEM_RANGE_CHK_EN
    assign in_range = exm_q.alu_out < DMEM_DEPTH;
`else
    assign in_range = 1'b1;
`endif

    logic ld_hit, st_hit;
    assign ld_hit = exm_q.valid & is_load(exm_q.opcode) & in_range;
    assign st_hit = exm_q.valid & is_store(exm_q.opcode) & in_range;

    logic [3:0] be;
    always_comb begin
        be = 4'b0000;
        case (exm_q.opcode)
            OP_SB:   be = 4'b0001;
            OP_SH:   be = 4'b0011;
            OP_SW:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // A store commits on the edge ending its MEM cycle; stall or reset on that edge drops it.
    logic              dmem_we;
    logic [DATA_W-1:0] rdata;
    assign dmem_we = st_hit & ~bus.stall & ~rst;

    mips_dmem #(
        .Depth (DMEM_DEPTH),
        .Aw    (AW)
    ) u_dmem (
        .clk_i   (clk),
        .we_i    (dmem_we),
        .be_i    (be),
        .addr_i  (exm_q.alu_out[AW-1:0]),
        .wdata_i (exm_q.store_data),
        .rdata_o (rdata)
    );

    logic [DATA_W-1:0] mem_out;
    always_comb begin
        mem_out = '0;
        if (ld_hit) begin
            case (exm_q.opcode)
                OP_LB:            mem_out = {{24{rdata[7]}}, rdata[7:0]};
                OP_LH:            mem_out = {{16{rdata[15]}}, rdata[15:0]};
                OP_LW_ALT, OP_LW: mem_out = rdata;
                OP_LBU:           mem_out = {24'h0, rdata[7:0]};
                OP_LHU:           mem_out = {16'h0, rdata[15:0]};
                default:          mem_out = '0;
            endcase
        end
    end

    assign bus.w_mem_out_data = mem_out;

    logic [DATA_W-1:0] wb_data_d, wb_data_q;
    logic [4:0]        wb_addr_d, wb_addr_q;
    logic              wb_en_d, wb_en_q;

    always_comb begin
        wb_data_d = is_load(exm_q.opcode) ? mem_out : exm_q.alu_out;
        wb_addr_d = exm_q.wr_addr;
        wb_en_d   = exm_q.valid & exm_q.wr_en & (exm_q.wr_addr != 5'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_data_q <= '0;
            wb_addr_q <= '0;
            wb_en_q   <= 1'b0;
        end else if (!bus.stall) begin
            wb_data_q <= wb_data_d;
            wb_addr_q <= wb_addr_d;
            wb_en_q   <= wb_en_d;
        end
    end

    assign bus.w_wb_wr_data = wb_data_q;
    assign bus.w_wb_wr_addr = wb_addr_q;
    assign bus.w_wb_wr_en   = wb_en_q;

`ifdef MIPS_MEM_RANGE_CHK_EN
    logic err_q;
    logic err_set;
    assign err_set = exm_q.valid & (is_load(exm_q.opcode) | is_store(exm_q.opcode)) & ~in_range;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    assign bus.mem_err = err_q;
`else
    assign bus.mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_mips_mem_stage.sv
// Self-checking bench for mips_mem_stage: directed scenarios plus randomized traffic
// against an instruction-level reference model (honours MIPS_MEM_RANGE_CHK_EN).
module tb_mips_mem_stage;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mips_mem_stage_if bus_if ();

    mips_mem_stage #(
        .DMEM_DEPTH (1024),
        .AW         (10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    typedef struct {
        bit        valid;
        bit [5:0]  op;
        bit [31:0] alu;
        bit [31:0] sd;
        bit [4:0]  wa;
        bit        we;
    } instr_t;

    int        total = 0;
    int        bad   = 0;
    bit [31:0] ref_mem [1024];
    instr_t    in_mem;
    bit        exp_wb_en;
    bit [31:0] exp_wb_data;
    bit [4:0]  exp_wb_addr;
    bit        ref_err;
    bit [5:0]  ops [12] = '{6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37,
                            6'd40, 6'd41, 6'd43, 6'd0, 6'd8, 6'd4};

    function automatic instr_t mk(bit v, bit [5:0] op, bit [31:0] alu, bit [31:0] sd,
                                  bit [4:0] wa, bit we);
        instr_t r;
        r.valid = v; r.op = op; r.alu = alu; r.sd = sd; r.wa = wa; r.we = we;
        return r;
    endfunction

    function automatic bit is_ld(bit [5:0] op);
        return op >= 32 && op <= 37;
    endfunction

    function automatic bit is_st(bit [5:0] op);
        return op == 40 || op == 41 || op == 43;
    endfunction

    function automatic bit in_rng(bit [31:0] a);
`ifdef MIPS_MEM_RANGE_CHK_EN
        return a < 1024;
`else
        return a == a;
`endif
    endfunction

    function automatic bit [31:0] ld_val(instr_t x);
        bit [31:0] w, b, h;
        if (!x.valid || !is_ld(x.op) || !in_rng(x.alu)) return 32'h0;
        w = ref_mem[x.alu % 1024];
        b = w % 256;
        h = w % 65536;
        case (x.op)
            6'd32:        return (b >= 128) ? b + 32'hFFFFFF00 : b;
            6'd33:        return (h >= 32768) ? h + 32'hFFFF0000 : h;
            6'd34, 6'd35: return w;
            6'd36:        return b;
            default:      return h;
        endcase
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(instr_t x);
        bus_if.ex_valid      = x.valid;
        bus_if.ex_opcode     = x.op;
        bus_if.ex_alu_out    = x.alu;
        bus_if.ex_store_data = x.sd;
        bus_if.ex_wr_addr    = x.wa;
        bus_if.ex_wr_en      = x.we;
    endtask

    // Effects of the instruction leaving MEM on a non-stalled, non-reset edge.
    task automatic model_edge();
        int unsigned i;
        exp_wb_en = 1'b0;
        if (in_mem.valid) begin
            if ((is_ld(in_mem.op) || is_st(in_mem.op)) && !in_rng(in_mem.alu)) ref_err = 1'b1;
            exp_wb_en   = in_mem.we && in_mem.wa != 0;
            exp_wb_data = is_ld(in_mem.op) ? ld_val(in_mem) : in_mem.alu;
            exp_wb_addr = in_mem.wa;
            if (is_st(in_mem.op) && in_rng(in_mem.alu)) begin
                i = in_mem.alu % 1024;
                case (in_mem.op)
                    6'd40:   ref_mem[i] = ref_mem[i] - ref_mem[i] % 256 + in_mem.sd % 256;
                    6'd41:   ref_mem[i] = ref_mem[i] - ref_mem[i] % 65536 + in_mem.sd % 65536;
                    default: ref_mem[i] = in_mem.sd;
                endcase
            end
        end
    endtask

    task automatic check_outputs();
        check("wb_en", 32'(bus_if.w_wb_wr_en), 32'(exp_wb_en));
        if (exp_wb_en) begin
            check("wb_data", bus_if.w_wb_wr_data, exp_wb_data);
            check("wb_addr", 32'(bus_if.w_wb_wr_addr), 32'(exp_wb_addr));
        end
        check("mem_out", bus_if.w_mem_out_data, ld_val(in_mem));
        check("mem_err", 32'(bus_if.mem_err), 32'(ref_err));
    endtask

    task automatic step(instr_t x, bit fl);
        bus_if.stall = 1'b0;
        bus_if.flush = fl;
        drive(x);
        @(posedge clk);
        model_edge();
        in_mem = x;
        if (fl) in_mem.valid = 1'b0;
        #1;
        check_outputs();
    endtask

    // EX carries junk while stalled; nothing may be captured or written.
    task automatic stall_for(int n, instr_t junk);
        bus_if.stall = 1'b1;
        bus_if.flush = 1'b0;
        drive(junk);
        repeat (n) begin
            @(posedge clk);
            #1;
            check_outputs();
        end
        bus_if.stall = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus_if.stall = 1'b0;
        bus_if.flush = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        in_mem.valid = 1'b0;
        exp_wb_en    = 1'b0;
        ref_err      = 1'b0;
        check("rst_wb_en", 32'(bus_if.w_wb_wr_en), 32'h0);
        check("rst_wb_data", bus_if.w_wb_wr_data, 32'h0);
        check("rst_wb_addr", 32'(bus_if.w_wb_wr_addr), 32'h0);
        check("rst_mem_out", bus_if.w_mem_out_data, 32'h0);
        check("rst_mem_err", 32'(bus_if.mem_err), 32'h0);
        rst = 1'b0;
    endtask

    initial begin
        instr_t    x;
        bit [5:0]  op;
        bit [31:0] alu;
        bit [31:0] old50;

        in_mem = mk(0, 0, 0, 0, 0, 0);
        exp_wb_en = 0; exp_wb_data = 0; exp_wb_addr = 0; ref_err = 0;
        rst = 1'b1;
        bus_if.stall = 1'b0;
        bus_if.flush = 1'b0;
        drive(in_mem);
        @(posedge clk);
        do_reset();

        // Known contents for the low 64 words used by everything below.
        for (int i = 0; i < 64; i++) step(mk(1, OP_SW, 32'(i), $urandom, 0, 0), 0);

        // Store then load of the same word, then write-back.
        step(mk(1, OP_SW, 4, 32'hDEADBEEF, 5, 0), 0);
        step(mk(1, OP_LW, 4, 0, 7, 1), 0);
        check("t1_lw_data", bus_if.w_mem_out_data, 32'hDEADBEEF);
        step(mk(0, 0, 0, 0, 0, 0), 0);
        check("t1_wb_data", bus_if.w_wb_wr_data, 32'hDEADBEEF);
        check("t1_wb_addr", 32'(bus_if.w_wb_wr_addr), 32'd7);
        check("t1_wb_en", 32'(bus_if.w_wb_wr_en), 32'd1);

        // Sub-word extension.
        step(mk(1, OP_SW, 8, 32'h000080F0, 0, 0), 0);
        step(mk(1, OP_LB, 8, 0, 1, 1), 0);
        check("t2_lb", bus_if.w_mem_out_data, 32'hFFFFFFF0);
        step(mk(1, OP_LBU, 8, 0, 1, 1), 0);
        check("t2_lbu", bus_if.w_mem_out_data, 32'h000000F0);
        step(mk(1, OP_LH, 8, 0, 1, 1), 0);
        check("t2_lh", bus_if.w_mem_out_data, 32'hFFFF80F0);
        step(mk(1, OP_LHU, 8, 0, 1, 1), 0);
        check("t2_lhu", bus_if.w_mem_out_data, 32'h000080F0);

        // Partial stores keep the untouched lanes.
        step(mk(1, OP_SW, 2, 32'h11223344, 0, 0), 0);
        step(mk(1, OP_SB, 2, 32'h000000AA, 0, 0), 0);
        step(mk(1, OP_SH, 2, 32'h0000BBCC, 0, 0), 0);
        step(mk(1, OP_LW, 2, 0, 2, 1), 0);
        check("t3_lw", bus_if.w_mem_out_data, 32'h1122BBCC);

        // Stalled store commits once after release; WB frozen meanwhile.
        step(mk(1, OP_LW, 4, 0, 3, 1), 0);
        step(mk(1, OP_SW, 9, 32'h00000055, 0, 0), 0);
        stall_for(3, mk(1, OP_SW, 9, 32'hFFFFFFFF, 0, 0));
        check("t4_frozen_wb", bus_if.w_wb_wr_data, 32'hDEADBEEF);
        step(mk(1, OP_LW, 9, 0, 4, 1), 0);
        check("t4_after_stall", bus_if.w_mem_out_data, 32'h00000055);
        step(mk(1, OP_LW, 4, 0, 6, 1), 1);
        step(mk(0, 0, 0, 0, 0, 0), 0);
        check("t4_flush_wb_en", 32'(bus_if.w_wb_wr_en), 32'd0);

        // r0 squash and ALU pass-through.
        step(mk(1, OP_RTYPE, 7, 0, 0, 1), 0);
        step(mk(1, 6'd8, 32'h10, 0, 9, 1), 0);
        check("t5_r0_squash", 32'(bus_if.w_wb_wr_en), 32'd0);
        check("t5_addi_mem_out", bus_if.w_mem_out_data, 32'h0);
        step(mk(0, 0, 0, 0, 0, 0), 0);
        check("t5_addi_wb", bus_if.w_wb_wr_data, 32'h10);

        // Reset while a store sits in MEM drops it.
        old50 = ref_mem[50];
        step(mk(1, OP_SW, 50, ~old50, 0, 0), 0);
        do_reset();
        step(mk(1, OP_LW, 50, 0, 5, 1), 0);
        check("rst_drop_store", bus_if.w_mem_out_data, old50);

        // Index at DMEM_DEPTH: wraps, or flags an error with range checking.
        step(mk(1, OP_LW, 1024, 0, 1, 1), 0);
`ifdef MIPS_MEM_RANGE_CHK_EN
        check("t6_oob_data", bus_if.w_mem_out_data, 32'h0);
        step(mk(0, 0, 0, 0, 0, 0), 0);
        check("t6_err_set", 32'(bus_if.mem_err), 32'd1);
        step(mk(1, OP_LW, 3, 0, 1, 1), 0);
        check("t6_err_sticky", 32'(bus_if.mem_err), 32'd1);
`else
        check("t6_wrap", bus_if.w_mem_out_data, ref_mem[0]);
`endif

        for (int i = 0; i < 300; i++) begin
            op  = ops[$urandom_range(0, 11)];
            alu = $urandom;
            if (is_ld(op) || is_st(op)) begin
                alu = 32'($urandom_range(0, 63));
`ifndef MIPS_MEM_RANGE_CHK_EN
                alu = alu + 32'(1024 * $urandom_range(0, 3));
`endif
            end
            x = mk($urandom_range(0, 7) != 0, op, alu, $urandom, 5'($urandom_range(0, 31)),
                   is_ld(op) || op == 6'd0 || op == 6'd8);
            step(x, $urandom_range(0, 9) == 0);
            if ($urandom_range(0, 14) == 0) begin
                stall_for(int'($urandom_range(1, 3)),
                          mk(1, OP_SW, 32'($urandom_range(0, 63)), $urandom, 0, 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
